// File: rtl/demux_pkg.sv
// Shared constants and helpers for the two-lane demux FIFO.
package demux_pkg;

  localparam int unsigned BW_DEF    = 2;
  localparam int unsigned DEPTH_DEF = 4;

  localparam logic LANE0 = 1'b0;
  localparam logic LANE1 = 1'b1;

  // Pointer width for a power-of-two depth.
  function automatic int unsigned aw_of(input int unsigned depth);
    int unsigned w;
    w = 0;
    while ((32'd1 << w) < depth) w++;
    return w;
  endfunction

endpackage

// File: rtl/demux_fifo_1a2_fifo_lane.sv
// One first-word-fall-through FIFO lane; refuses push when full, ignores pop when empty.
module fifo_lane
  import demux_pkg::*;
#(
  parameter int unsigned BW    = BW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          i_push,
  input  logic [BW-1:0] i_data,
  input  logic          i_pop,
  output logic [BW-1:0] o_data,
  output logic          o_full,
  output logic          o_empty
);

  localparam int unsigned AW = aw_of(DEPTH);

  logic [BW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Head is forced to zero while empty so reset shows a clean output.
  assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally at AW bits since DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/demux_fifo_1a2.sv
// Routes mux words into two FWFT lanes by selector; sticky overflow err under DEMUX_OVF_ERR_EN.
module demux_fifo_1a2
  import demux_pkg::*;
#(
  parameter int unsigned BW    = BW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic [BW-1:0] data_in,
  input  logic          valid_in,
  input  logic          selector,
  output logic          ready_in,
  output logic [BW-1:0] data_out0,
  output logic          valid_out0,
  input  logic          pop0,
  output logic [BW-1:0] data_out1,
  output logic          valid_out1,
  input  logic          pop1,
  output logic          full0,
  output logic          full1,
  output logic          empty0,
  output logic          empty1,
  output logic          err
);

  logic w_push0;
  logic w_push1;
  logic w_sel_full;

  assign w_push0    = valid_in && (selector == LANE0);
  assign w_push1    = valid_in && (selector == LANE1);
  assign w_sel_full = (selector == LANE1) ? full1 : full0;
  assign ready_in   = !w_sel_full;
  assign valid_out0 = !empty0;
  assign valid_out1 = !empty1;

  fifo_lane #(.BW(BW), .DEPTH(DEPTH)) u_lane0 (
    .clk     (clk),
    .reset_L (reset_L),
    .i_push  (w_push0),
    .i_data  (data_in),
    .i_pop   (pop0),
    .o_data  (data_out0),
    .o_full  (full0),
    .o_empty (empty0)
  );

  fifo_lane #(.BW(BW), .DEPTH(DEPTH)) u_lane1 (
    .clk     (clk),
    .reset_L (reset_L),
    .i_push  (w_push1),
    .i_data  (data_in),
    .i_pop   (pop1),
    .o_data  (data_out1),
    .o_full  (full1),
    .o_empty (empty1)
  );

`ifdef DEMUX_OVF_ERR_EN
  logic r_err;

  // Sticky until reset: any word offered to a full lane is lost.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                    r_err <= 1'b0;
    else if (valid_in && w_sel_full) r_err <= 1'b1;
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_demux_fifo_1a2.sv
// Directed-vector bench for demux_fifo_1a2 (err expectation follows DEMUX_OVF_ERR_EN).
module tb_demux_fifo_1a2;

  logic       clk = 1'b0;
  logic       reset_L;
  logic [1:0] data_in;
  logic       valid_in;
  logic       selector;
  logic       ready_in;
  logic [1:0] data_out0;
  logic       valid_out0;
  logic       pop0;
  logic [1:0] data_out1;
  logic       valid_out1;
  logic       pop1;
  logic       full0, full1, empty0, empty1, err;

  int n_checks = 0;
  int n_errors = 0;

`ifdef DEMUX_OVF_ERR_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  demux_fifo_1a2 #(.BW(2), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_L    (reset_L),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .selector   (selector),
    .ready_in   (ready_in),
    .data_out0  (data_out0),
    .valid_out0 (valid_out0),
    .pop0       (pop0),
    .data_out1  (data_out1),
    .valid_out1 (valid_out1),
    .pop1       (pop1),
    .full0      (full0),
    .full1      (full1),
    .empty0     (empty0),
    .empty1     (empty1),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one rising edge, then settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic sel, input logic [1:0] d);
    valid_in = 1'b1; selector = sel; data_in = d;
    step();
    valid_in = 1'b0;
  endtask

  task automatic pop_lane(input logic lane);
    if (lane) pop1 = 1'b1; else pop0 = 1'b1;
    step();
    pop0 = 1'b0; pop1 = 1'b0;
  endtask

  logic [1:0] q1[$];
  logic [1:0] exp_seq[4];
  logic [1:0] wrap_in[6];

  initial begin
    reset_L = 1'b0; data_in = '0; valid_in = 1'b0; selector = 1'b0; pop0 = 1'b0; pop1 = 1'b0;
    repeat (2) step();
    check("rst_empty0", 8'(empty0), 8'd1);
    check("rst_empty1", 8'(empty1), 8'd1);
    check("rst_full0", 8'(full0), 8'd0);
    check("rst_valid0", 8'(valid_out0), 8'd0);
    check("rst_data0", 8'(data_out0), 8'd0);
    check("rst_err", 8'(err), 8'd0);
    reset_L = 1'b1;

    // 1: first push visible after one edge
    push(1'b0, 2'b11);
    check("t1_valid0", 8'(valid_out0), 8'd1);
    check("t1_data0", 8'(data_out0), 8'd3);
    check("t1_empty1", 8'(empty1), 8'd1);
    check("t1_ready", 8'(ready_in), 8'd1);
    pop_lane(1'b0);
    check("t1_drained", 8'(empty0), 8'd1);

    // 2: alternating routes keep per-lane order
    push(1'b1, 2'b01); push(1'b0, 2'b10); push(1'b1, 2'b00);
    check("t2_l1_head", 8'(data_out1), 8'd1);
    pop_lane(1'b1);
    check("t2_l1_next", 8'(data_out1), 8'd0);
    check("t2_l1_valid", 8'(valid_out1), 8'd1);
    pop_lane(1'b1);
    check("t2_l1_empty", 8'(empty1), 8'd1);
    check("t2_l0_head", 8'(data_out0), 8'd2);
    pop_lane(1'b0);
    check("t2_l0_empty", 8'(empty0), 8'd1);

    // 5: empty-lane edge cases (before overflow so err is still clear)
    pop_lane(1'b1);
    check("t5_pop_empty", 8'(empty1), 8'd1);
    check("t5_err", 8'(err), 8'd0);
    pop1 = 1'b1;
    push(1'b1, 2'b10);
    pop1 = 1'b0;
    check("t5_pp_valid", 8'(valid_out1), 8'd1);
    check("t5_pp_data", 8'(data_out1), 8'd2);
    pop_lane(1'b1);
    check("t5_pp_count1", 8'(empty1), 8'd1);

    // 4: steady push+pop across the pointer wrap
    push(1'b1, 2'b01); push(1'b1, 2'b10); push(1'b1, 2'b11);
    q1 = '{2'b01, 2'b10, 2'b11};
    wrap_in = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 6; i++) begin
      check("t4_head", 8'(data_out1), 8'(q1[0]));
      void'(q1.pop_front());
      q1.push_back(wrap_in[i]);
      pop1 = 1'b1;
      push(1'b1, wrap_in[i]);
      pop1 = 1'b0;
      check("t4_full1", 8'(full1), 8'd0);
    end
    for (int i = 0; i < 3; i++) begin
      check("t4_drain", 8'(data_out1), 8'(q1[i]));
      pop_lane(1'b1);
    end
    check("t4_count3", 8'(empty1), 8'd1);

    // 3: fill lane 0, overflow, drain
    exp_seq = '{2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) push(1'b0, exp_seq[i]);
    selector = 1'b0; #1;
    check("t3_full0", 8'(full0), 8'd1);
    check("t3_ready0", 8'(ready_in), 8'd0);
    selector = 1'b1; #1;
    check("t3_ready1", 8'(ready_in), 8'd1);
    pop0 = 1'b1;
    push(1'b0, 2'b11);
    pop0 = 1'b0;
    check("t3_err", 8'(err), 8'(EXP_OVF));
    check("t3_still_full", 8'(full0), 8'd0);
    // The concurrent pop took 11; the refused word must not reappear.
    for (int i = 1; i < 4; i++) begin
      check("t3_pop", 8'(data_out0), 8'(exp_seq[i]));
      pop_lane(1'b0);
    end
    check("t3_empty0", 8'(empty0), 8'd1);
    check("t3_err_sticky", 8'(err), 8'(EXP_OVF));

    // 6: asynchronous reset mid-operation
    push(1'b0, 2'b10); push(1'b0, 2'b11); push(1'b1, 2'b01);
    #2 reset_L = 1'b0;
    #1;
    check("t6_empty0", 8'(empty0), 8'd1);
    check("t6_empty1", 8'(empty1), 8'd1);
    check("t6_data0", 8'(data_out0), 8'd0);
    check("t6_valid1", 8'(valid_out1), 8'd0);
    check("t6_err", 8'(err), 8'd0);
    step();
    reset_L = 1'b1;
    push(1'b0, 2'b01);
    check("t6_data_new", 8'(data_out0), 8'd1);
    check("t6_empty1_after", 8'(empty1), 8'd1);
    pop_lane(1'b0);
    check("t6_only_word", 8'(empty0), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
